// File: rtl/collection_drain_reader_if.sv
`default_nettype none
// ============================================================================
//  Module      : collection_drain_reader_if
//  Description : Collector read port plus per-address result stream.
//  Revision    : 1.0 - initial release
// ============================================================================
interface collection_drain_reader_if #(
    parameter int ADDR_WIDTH = 12
);
    logic [ADDR_WIDTH-1:0] readAddr;
    logic                  readIssue;
    logic [37:0]           summedDataOut;
    logic [2:0]            pcoeffCount;
    logic                  resultValid;
    logic                  resultReady;
    logic [ADDR_WIDTH-1:0] resultAddr;
    logic [37:0]           resultSum;
    logic [2:0]            resultCount;

    modport master (
        output readAddr, readIssue, resultValid, resultAddr, resultSum, resultCount,
        input  summedDataOut, pcoeffCount, resultReady
    );

    modport slave (
        input  readAddr, readIssue, resultValid, resultAddr, resultSum, resultCount,
        output summedDataOut, pcoeffCount, resultReady
    );
endinterface
`default_nettype wire

// File: rtl/collection_drain_reader.sv
`default_nettype none
// ============================================================================
//  Module      : collection_drain_reader
//  Description : Sweeps the collection memory once per start with destructive
//                reads and streams per-address results through a credit-checked FIFO.
//  Revision    : 1.0 - initial release
// ============================================================================
module collection_drain_reader #(
    parameter int ADDR_WIDTH   = 12,
    parameter int READ_LATENCY = 6,
    parameter int FIFO_DEPTH   = 16,
    parameter bit SKIP_EMPTY   = 1'b0
) (
    input  wire logic                  clk,
    input  wire logic                  rst_n,
    input  wire logic                  start,
    output logic                       busy,
    output logic                       done,
    output logic [ADDR_WIDTH+2:0]      totalCount,
    collection_drain_reader_if.master  bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int INF_W = $clog2(READ_LATENCY) + 1;
    localparam int SUM_W = ((CNT_W > INF_W) ? CNT_W : INF_W) + 1;
    localparam int TOT_W = ADDR_WIDTH + 3;
    localparam int ENT_W = ADDR_WIDTH + 41;

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_SWEEP = 2'd1;
    localparam logic [1:0] c_DRAIN = 2'd2;
    localparam logic [1:0] c_DONE  = 2'd3;
    localparam logic [ADDR_WIDTH-1:0] c_lastAddr = '1;

    logic [1:0]              r_state;
    logic [ADDR_WIDTH-1:0]   r_readAddr;
    logic [READ_LATENCY-1:0] r_tagValid;
    logic [ADDR_WIDTH-1:0]   r_tagAddr [READ_LATENCY];
    logic [INF_W-1:0]        r_inFlight;
    logic [CNT_W-1:0]        r_fifoCount;
    logic [PTR_W-1:0]        r_wrPtr;
    logic [PTR_W-1:0]        r_rdPtr;
    logic [ENT_W-1:0]        r_mem [FIFO_DEPTH];
    logic [TOT_W-1:0]        r_totalCount;

    logic w_issue;
    logic w_capture;
    logic w_push;
    logic w_pop;

    // A read is only issued when its result is guaranteed a FIFO slot on return.
    assign w_issue   = (r_state == c_SWEEP) &&
                       ((SUM_W'(r_fifoCount) + SUM_W'(r_inFlight)) < SUM_W'(FIFO_DEPTH));
    assign w_capture = r_tagValid[READ_LATENCY-1];
    assign w_push    = w_capture && !(SKIP_EMPTY && (bus.pcoeffCount == 3'd0));
    assign w_pop     = (r_fifoCount != '0) && bus.resultReady;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= c_IDLE;
            r_readAddr   <= '0;
            r_tagValid   <= '0;
            r_inFlight   <= '0;
            r_fifoCount  <= '0;
            r_wrPtr      <= '0;
            r_rdPtr      <= '0;
            r_totalCount <= '0;
        end else begin
            case (r_state)
                c_IDLE: if (start) begin
                    r_state      <= c_SWEEP;
                    r_readAddr   <= '0;
                    r_totalCount <= '0;
                end
                c_SWEEP: if (w_issue) begin
                    r_readAddr <= r_readAddr + ADDR_WIDTH'(1);
                    if (r_readAddr == c_lastAddr) r_state <= c_DRAIN;
                end
                c_DRAIN: if ((r_inFlight == '0) && (r_fifoCount == '0)) r_state <= c_DONE;
                default: r_state <= c_IDLE;
            endcase

            r_tagValid <= {r_tagValid[READ_LATENCY-2:0], w_issue};
            case ({w_issue, w_capture})
                2'b10:   r_inFlight <= r_inFlight + INF_W'(1);
                2'b01:   r_inFlight <= r_inFlight - INF_W'(1);
                default: ;
            endcase

            if (w_capture) r_totalCount <= r_totalCount + TOT_W'(bus.pcoeffCount);

            case ({w_push, w_pop})
                2'b10:   r_fifoCount <= r_fifoCount + CNT_W'(1);
                2'b01:   r_fifoCount <= r_fifoCount - CNT_W'(1);
                default: ;
            endcase
            if (w_push) r_wrPtr <= r_wrPtr + PTR_W'(1);
            if (w_pop)  r_rdPtr <= r_rdPtr + PTR_W'(1);
        end
    end

    // Address side of the tag pipe and FIFO storage need no reset: valid bits guard them.
    always_ff @(posedge clk) begin
        r_tagAddr[0] <= r_readAddr;
        for (int i = 1; i < READ_LATENCY; i++) r_tagAddr[i] <= r_tagAddr[i-1];
        if (w_push) r_mem[r_wrPtr] <= {r_tagAddr[READ_LATENCY-1], bus.summedDataOut, bus.pcoeffCount};
    end

    a_noOverflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(w_push && (r_fifoCount == CNT_W'(FIFO_DEPTH))));

    assign bus.readAddr    = r_readAddr;
    assign bus.readIssue   = w_issue;
    assign bus.resultValid = (r_fifoCount != '0);
    assign {bus.resultAddr, bus.resultSum, bus.resultCount} = r_mem[r_rdPtr];
    assign busy            = (r_state == c_SWEEP) || (r_state == c_DRAIN);
    assign done            = (r_state == c_DONE);
    assign totalCount      = r_totalCount;
endmodule
`default_nettype wire

// File: tb/tb_collection_drain_reader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_collection_drain_reader
//  Description : Two drain readers (plain, depth 8 / skip-empty, depth 16) against
//                a destructive-read collector model and a result scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_collection_drain_reader;
    localparam int AW = 4;
    localparam int RL = 6;
    localparam int NA = 16;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [37:0]   sum;
        logic [2:0]    cnt;
    } res_t;

    typedef struct {
        int          inst;
        int          pct;
        int          a0;
        logic [37:0] s0;
        logic [2:0]  c0;
        int          a1;
        logic [37:0] s1;
        logic [2:0]  c1;
        int          expTotal;
        int          expResults;
    } vec_t;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  start = '0;
    logic [1:0]  ready = '0;
    logic [1:0]  load  = '0;
    logic [1:0]  busy;
    logic [1:0]  done;
    logic [AW+2:0] total [2];
    logic [37:0] preSum [NA];
    logic [2:0]  preCnt [NA];

    res_t sbq [2][$];
    vec_t vecs [5];
    int nCmp = 0, nFail = 0, cycNo = 0;
    int acc [2], lastAcc [2], doneCnt [2], doneCyc [2], issues [2], lastIss [2], nextAddr [2];

    always #5 clk = ~clk;

    collection_drain_reader_if #(.ADDR_WIDTH(AW)) bus [2] ();

    for (genvar g = 0; g < 2; g++) begin : g_inst
        logic [37:0] memS  [NA];
        logic [2:0]  memC  [NA];
        logic [37:0] pipeS [RL];
        logic [2:0]  pipeC [RL];

        collection_drain_reader #(
            .ADDR_WIDTH(AW), .READ_LATENCY(RL),
            .FIFO_DEPTH(g ? 16 : 8), .SKIP_EMPTY(g == 1)
        ) u_dut (
            .clk(clk), .rst_n(rst_n), .start(start[g]), .busy(busy[g]),
            .done(done[g]), .totalCount(total[g]), .bus(bus[g])
        );

        // Destructive collector: an issued read returns the entry and wipes it.
        always @(posedge clk) begin
            if (load[g]) begin
                for (int i = 0; i < NA; i++) begin
                    memS[i] <= preSum[i];
                    memC[i] <= preCnt[i];
                end
            end else if (bus[g].readIssue) begin
                memS[bus[g].readAddr] <= '0;
                memC[bus[g].readAddr] <= '0;
            end
            pipeS[0] <= bus[g].readIssue ? memS[bus[g].readAddr] : '0;
            pipeC[0] <= bus[g].readIssue ? memC[bus[g].readAddr] : '0;
            for (int i = 1; i < RL; i++) begin
                pipeS[i] <= pipeS[i-1];
                pipeC[i] <= pipeC[i-1];
            end
        end
        assign bus[g].summedDataOut = pipeS[RL-1];
        assign bus[g].pcoeffCount   = pipeC[RL-1];
        assign bus[g].resultReady   = ready[g];
    end

    task automatic chk(string name, logic [63:0] got, logic [63:0] exp);
        nCmp++;
        if (got !== exp) begin
            nFail++;
            $display("FAIL %s: actual %0h, required %0h (cycle %0d)", name, got, exp, cycNo);
        end
    endtask

    task automatic sample_one(int g, logic v, logic iss, logic [AW-1:0] ra, res_t head, logic dn);
        res_t e;
        if (iss) begin
            chk("issueAddr", 64'(ra), 64'(nextAddr[g]));
            nextAddr[g] = (nextAddr[g] + 1) % NA;
            issues[g]++;
            lastIss[g] = cycNo;
        end
        if (v && ready[g]) begin
            if (sbq[g].size() == 0) begin
                nCmp++;
                nFail++;
                $display("FAIL unexpectedResult inst%0d: actual %0h, required none", g, head);
            end else begin
                e = sbq[g].pop_front();
                chk("result", 64'(head), 64'(e));
            end
            acc[g]++;
            lastAcc[g] = cycNo;
        end
        if (dn) begin
            doneCnt[g]++;
            doneCyc[g] = cycNo;
        end
    endtask

    task automatic step();
        #3;
        sample_one(0, bus[0].resultValid, bus[0].readIssue, bus[0].readAddr,
                   {bus[0].resultAddr, bus[0].resultSum, bus[0].resultCount}, done[0]);
        sample_one(1, bus[1].resultValid, bus[1].readIssue, bus[1].readAddr,
                   {bus[1].resultAddr, bus[1].resultSum, bus[1].resultCount}, done[1]);
        @(posedge clk);
        #1;
        cycNo++;
    endtask

    task automatic set_pre(vec_t v);
        for (int a = 0; a < NA; a++) begin
            preSum[a] = '0;
            preCnt[a] = '0;
        end
        if (v.a0 >= 0) begin preSum[v.a0] = v.s0; preCnt[v.a0] = v.c0; end
        if (v.a1 >= 0) begin preSum[v.a1] = v.s1; preCnt[v.a1] = v.c1; end
    endtask

    task automatic begin_sweep(int g);
        acc[g] = 0; doneCnt[g] = 0; issues[g] = 0; nextAddr[g] = 0;
        lastAcc[g] = -100; doneCyc[g] = -100; lastIss[g] = -100;
        sbq[g].delete();
        load[g] = 1'b1;
        step();
        load[g] = 1'b0;
        for (int a = 0; a < NA; a++)
            if (!(g == 1 && preCnt[a] == 3'd0)) sbq[g].push_back({AW'(a), preSum[a], preCnt[a]});
        start[g] = 1'b1;
        step();
        start[g] = 1'b0;
    endtask

    task automatic run_sweep(int g, int pct, int hold, int expTotal, int expRes);
        int t;
        begin_sweep(g);
        t = 0;
        while (doneCnt[g] == 0 && t < 600) begin
            ready[g] = (t < hold) ? 1'b0 : 1'($urandom_range(99) < pct);
            start[g] = busy[g] && (t % 5 == 2);
            if (hold > 0 && t == hold - 1) begin
                chk("stallIssues", 64'(issues[0]), 64'd8);
                chk("stallIssueLow", 64'(bus[0].readIssue), 64'd0);
                chk("stallValid", 64'(bus[0].resultValid), 64'd1);
            end
            step();
            t++;
        end
        start[g] = 1'b0;
        ready[g] = 1'b1;
        if (doneCnt[g] == 0) begin
            nCmp++;
            nFail++;
            $display("FAIL doneTimeout inst%0d: actual no done, required done within 600 cycles", g);
        end
        repeat (4) step();
        chk("doneCount", 64'(doneCnt[g]), 64'd1);
        chk("accepted", 64'(acc[g]), 64'(expRes));
        chk("totalCount", 64'(total[g]), 64'(expTotal));
        chk("leftover", 64'(sbq[g].size()), 64'd0);
        chk("doneAfterDrain", 64'(doneCyc[g] >= lastIss[g] + RL + 2), 64'd1);
        if (g == 0)
            chk("doneAfterAccept", 64'((doneCyc[g] - lastAcc[g] >= 1) && (doneCyc[g] - lastAcc[g] <= 2)), 64'd1);
        sbq[g].delete();
    endtask

    task automatic chk_idle(int g, logic iss, logic [AW-1:0] ra, logic v);
        chk("rstIssue", 64'(iss), 64'd0);
        chk("rstAddr", 64'(ra), 64'd0);
        chk("rstValid", 64'(v), 64'd0);
        chk("rstBusy", 64'(busy[g]), 64'd0);
        chk("rstDone", 64'(done[g]), 64'd0);
        chk("rstTotal", 64'(total[g]), 64'd0);
    endtask

    initial begin
        vecs[0] = '{0, 100, 3, 38'h25, 3'd3, -1, 38'h0, 3'd0, 3, 16};
        vecs[1] = '{0, 50, 5, 38'h1234, 3'd6, 15, 38'h3F_FFFF_FFFF, 3'd1, 7, 16};
        vecs[2] = '{1, 100, 1, 38'h11, 3'd2, 9, 38'h2A_0000_0001, 3'd4, 6, 2};
        vecs[3] = '{1, 50, 0, 38'h7, 3'd5, 15, 38'h9, 3'd6, 11, 2};
        vecs[4] = '{0, 30, 0, 38'h1, 3'd6, 15, 38'h2, 3'd6, 12, 16};

        repeat (3) @(posedge clk);
        #1;
        chk_idle(0, bus[0].readIssue, bus[0].readAddr, bus[0].resultValid);
        chk_idle(1, bus[1].readIssue, bus[1].readAddr, bus[1].resultValid);
        rst_n = 1'b1;
        repeat (RL + 2) step();

        for (int i = 0; i < 5; i++) begin
            set_pre(vecs[i]);
            run_sweep(vecs[i].inst, vecs[i].pct, 0, vecs[i].expTotal, vecs[i].expResults);
        end

        // Full backpressure from start: exactly 8 credits, then release.
        set_pre(vecs[0]);
        run_sweep(0, 100, 40, 3, 16);

        // Reset mid-sweep at address 7.
        set_pre(vecs[1]);
        begin_sweep(0);
        ready[0] = 1'b1;
        for (int t = 0; t < 50 && bus[0].readAddr != AW'(7); t++) step();
        chk("reachAddr7", 64'(bus[0].readAddr), 64'd7);
        rst_n = 1'b0;
        #1;
        chk_idle(0, bus[0].readIssue, bus[0].readAddr, bus[0].resultValid);
        step();
        step();
        rst_n = 1'b1;
        sbq[0].delete();
        repeat (RL + 2) step();

        set_pre(vecs[4]);
        run_sweep(0, 100, 0, 12, 16);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual timeout, required $finish before 200000");
        $fatal(1);
    end
endmodule
`default_nettype wire
